inert_seq: RTL

Sequencer that owns the SPI monarch port to the inertial sensor. After reset it waits out sensor power-up and issues a fixed three-command configuration. It then reads yaw-rate low and high bytes on every rising edge of the sensor's data-ready interrupt (INT). Each assembled 16-bit yaw rate is presented to the heading integrator with a one-cycle valid pulse.

---
 rtl/inert_pkg.sv | 36 +++
 rtl/inert_seq_if.sv | 24 ++
 rtl/inert_int_sync.sv | 19 +
 rtl/inert_seq.sv | 118 +++++++++++
 4 files changed

// File: rtl/inert_pkg.sv
// inert_seq shared types: sequencer states and SPI command words.
// INERT_SMPL_CNT_EN adds the sample counter and overrun flag in inert_seq.
package inert_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        CFG,
        CFG_W,
        IDLE,
        RDL,
        RDL_W,
        RDH,
        RDH_W
    } inert_state_t;

    localparam logic [15:0] CFG_CMD [3] = '{
        16'h0D02,
        16'h1160,
        16'h1440
    };

    localparam logic [15:0] RD_YAWL = 16'hA600;
    localparam logic [15:0] RD_YAWH = 16'hA700;

    function automatic logic [15:0] cfg_cmd(input logic [1:0] i);
        logic [15:0] c;
        c = CFG_CMD[2];
        case (i)
            2'd0: c = CFG_CMD[0];
            2'd1: c = CFG_CMD[1];
            default: c = CFG_CMD[2];
        endcase
        return c;
    endfunction

endpackage

// File: rtl/inert_seq_if.sv
// SPI monarch request/response bundle between inert_seq and the SPI block.
// master = sequencer side, slave = SPI monarch side.
interface inert_seq_if;

    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (
        output wrt,
        output cmd,
        input  done,
        input  rd_data
    );

    modport slave (
        input  wrt,
        input  cmd,
        output done,
        output rd_data
    );

endinterface

// File: rtl/inert_int_sync.sv
// Data-ready synchronizer: two metastability flops plus an edge flop,
// rise is high for one cycle per synchronized low-to-high transition.
module inert_int_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [2:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= 3'b000;
        else        ff <= {ff[1:0], din};
    end

    assign rise = ff[1] & ~ff[2];

endmodule

// File: rtl/inert_seq.sv
// Inertial sensor sequencer: power-up wait, 3-command config, yaw reads.
// INERT_SMPL_CNT_EN adds smpl_cnt and the sticky ovr flag.
module inert_seq
    import inert_pkg::*;
#(
    parameter int STARTUP_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    inert_seq_if.master spi,
    output logic [15:0] yaw_rt,
    output logic        vld,
`ifdef INERT_SMPL_CNT_EN
    output logic [15:0] smpl_cnt,
    output logic        ovr,
`endif
    output logic        busy
);

    localparam logic [STARTUP_BITS-1:0] CNT_ONE =
        {{(STARTUP_BITS-1){1'b0}}, 1'b1};

    inert_state_t            state;
    inert_state_t            nxt;
    logic [STARTUP_BITS-1:0] cnt;
    logic [1:0]              idx;
    logic [7:0]              lo;
    logic                    pend;
    logic                    rise;
    logic                    rd_phase;
    logic                    hi_done;

    inert_int_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (INT),
        .rise  (rise)
    );

    assign rd_phase = state inside {RDL, RDL_W, RDH, RDH_W};
    assign hi_done  = (state == RDH_W) && spi.done;
    assign busy     = (state != IDLE);

    always_comb begin
        nxt     = state;
        spi.wrt = 1'b0;
        spi.cmd = 16'h0000;
        unique case (state)
            PWRUP: if (&cnt) nxt = CFG;
            CFG: begin
                spi.wrt = 1'b1;
                spi.cmd = cfg_cmd(idx);
                nxt     = CFG_W;
            end
            CFG_W: begin
                spi.cmd = cfg_cmd(idx);
                if (spi.done) nxt = (idx == 2'd2) ? IDLE : CFG;
            end
            IDLE: if (rise || pend) nxt = RDL;
            RDL: begin
                spi.wrt = 1'b1;
                spi.cmd = RD_YAWL;
                nxt     = RDL_W;
            end
            RDL_W: begin
                spi.cmd = RD_YAWL;
                if (spi.done) nxt = RDH;
            end
            RDH: begin
                spi.wrt = 1'b1;
                spi.cmd = RD_YAWH;
                nxt     = RDH_W;
            end
            RDH_W: begin
                spi.cmd = RD_YAWH;
                if (spi.done) nxt = IDLE;
            end
            default: nxt = PWRUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= PWRUP;
            cnt    <= '0;
            idx    <= 2'd0;
            lo     <= 8'h00;
            pend   <= 1'b0;
            yaw_rt <= 16'h0000;
            vld    <= 1'b0;
        end else begin
            state <= nxt;
            vld   <= hi_done;
            if (state == PWRUP) cnt <= cnt + CNT_ONE;
            if (state == CFG_W && spi.done && idx != 2'd2)
                idx <= idx + 2'd1;
            if (state == RDL_W && spi.done) lo <= spi.rd_data[7:0];
            if (hi_done) yaw_rt <= {spi.rd_data[7:0], lo};
            // IDLE always consumes the flag; only read-phase rises queue up
            if (state == IDLE)         pend <= 1'b0;
            else if (rd_phase && rise) pend <= 1'b1;
        end
    end

`ifdef INERT_SMPL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smpl_cnt <= 16'h0000;
            ovr      <= 1'b0;
        end else begin
            if (hi_done)     smpl_cnt <= smpl_cnt + 16'd1;
            if (rise && pend) ovr     <= 1'b1;
        end
    end
`endif

endmodule
